// File: rtl/pwm_period_meas_if.sv
// Record channel of the PWM period meter: {period, width} records under a valid/ready handshake.
interface pwm_period_meas_if #(
    parameter int unsigned K_DWIDTH = 16
);
    logic                o_valid;
    logic                i_ready;
    logic [K_DWIDTH-1:0] o_period;
    logic [K_DWIDTH-1:0] o_width;

    modport master (output o_valid, output o_period, output o_width, input i_ready);
    modport slave  (input o_valid, input o_period, input o_width, output i_ready);
endinterface

// File: rtl/pwm_period_meas.sv
// Pairs captured PWM active widths with the start-to-start period, publishes {period, width}
// records, and flags stalled inputs and overwritten records.
module pwm_period_meas #(
    parameter int unsigned K_DWIDTH = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic                i_timebase,
    input  logic                i_pwm,
    input  logic                i_capture_start,
    input  logic                i_capture_done,
    input  logic [K_DWIDTH-1:0] i_capture_value,
    input  logic [K_DWIDTH-1:0] i_timeout,
    input  logic                i_clear,
    pwm_period_meas_if.master   rec,
    output logic                o_overrun,
    output logic                o_stalled,
    output logic                o_stall_level
);

    localparam logic [K_DWIDTH-1:0] CntMax = '1;
    localparam logic [K_DWIDTH-1:0] CntOne = K_DWIDTH'(1);
    localparam logic [K_DWIDTH:0]   ExtOne = (K_DWIDTH + 1)'(1);

    logic [K_DWIDTH-1:0] period_cnt_q, period_cnt_d;
    logic [K_DWIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [K_DWIDTH-1:0] width_reg_q, width_reg_d;
    logic                armed_q, armed_d;
    logic                width_ok_q, width_ok_d;
    logic                valid_q, valid_d;
    logic [K_DWIDTH-1:0] period_q, period_d;
    logic [K_DWIDTH-1:0] width_q, width_d;
    logic                overrun_q, overrun_d;
    logic                stalled_q, stalled_d;
    logic                level_q, level_d;

    logic                emit;
    logic                stall_hit;
    logic [K_DWIDTH-1:0] rec_width;
    logic [K_DWIDTH-1:0] tick_ext;
    logic [K_DWIDTH:0]   stall_inc;

    assign tick_ext  = {{(K_DWIDTH - 1){1'b0}}, i_timebase};
    // One extra bit so a saturated counter can never match the timeout again.
    assign stall_inc = {1'b0, stall_cnt_q} + ExtOne;

    always_comb begin
        period_cnt_d = period_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        width_reg_d  = width_reg_q;
        armed_d      = armed_q;
        width_ok_d   = width_ok_q;
        stalled_d    = stalled_q;
        level_d      = level_q;
        emit         = 1'b0;
        stall_hit    = 1'b0;
        rec_width    = width_reg_q;

        if (!i_enable) begin
            period_cnt_d = '0;
            stall_cnt_d  = '0;
            armed_d      = 1'b0;
            width_ok_d   = 1'b0;
            stalled_d    = 1'b0;
        end else begin
            // A done coincident with start belongs to the record emitted by that start.
            if (i_capture_done) begin
                width_reg_d = i_capture_value;
                width_ok_d  = 1'b1;
                rec_width   = i_capture_value;
            end
            if (i_capture_start) begin
                emit         = armed_q && (width_ok_q || i_capture_done);
                period_cnt_d = tick_ext;
                stall_cnt_d  = tick_ext;
                armed_d      = 1'b1;
                width_ok_d   = 1'b0;
                stalled_d    = 1'b0;
            end else if (i_timebase) begin
                if (period_cnt_q != CntMax) period_cnt_d = period_cnt_q + CntOne;
                if (stall_cnt_q != CntMax)  stall_cnt_d  = stall_cnt_q + CntOne;
                stall_hit = (i_timeout != '0) && (stall_inc == {1'b0, i_timeout});
            end
            if (stall_hit) begin
                stalled_d  = 1'b1;
                level_d    = i_pwm;
                armed_d    = 1'b0;
                width_ok_d = 1'b0;
            end
            if (i_timeout == '0) stall_cnt_d = '0;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        period_d  = period_q;
        width_d   = width_q;
        overrun_d = overrun_q;

        if (emit) begin
            valid_d  = 1'b1;
            period_d = period_cnt_q;
            width_d  = rec_width;
        end else if (valid_q && rec.i_ready) begin
            valid_d = 1'b0;
        end

        if (i_clear) overrun_d = 1'b0;
        if (emit && valid_q && !rec.i_ready) overrun_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            period_cnt_q <= '0;
            stall_cnt_q  <= '0;
            width_reg_q  <= '0;
            armed_q      <= 1'b0;
            width_ok_q   <= 1'b0;
            valid_q      <= 1'b0;
            period_q     <= '0;
            width_q      <= '0;
            overrun_q    <= 1'b0;
            stalled_q    <= 1'b0;
            level_q      <= 1'b0;
        end else begin
            period_cnt_q <= period_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            width_reg_q  <= width_reg_d;
            armed_q      <= armed_d;
            width_ok_q   <= width_ok_d;
            valid_q      <= valid_d;
            period_q     <= period_d;
            width_q      <= width_d;
            overrun_q    <= overrun_d;
            stalled_q    <= stalled_d;
            level_q      <= level_d;
        end
    end

    assign rec.o_valid    = valid_q;
    assign rec.o_period   = period_q;
    assign rec.o_width    = width_q;
    assign o_overrun      = overrun_q;
    assign o_stalled      = stalled_q;
    assign o_stall_level  = level_q;

endmodule
